ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine in the EX stage.
- Consumes the decoded fields the ID/EX pipeline register presents (ALUOp, funct7/funct3, operands, rd), which makes it the reader side of that register.
- While computing, drives stall_o so the hazard logic freezes PC, IF/ID and ID/EX. On completion it presents result_o for one cycle, and EX/MEM captures it.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- start_i  input  1  asynchronous active-low reset; low forces reset state immediately.
- ALUOp_i  input  2  ALUOp from ID/EX; 2'b10 = R-type.
- funct_7_3_i  input  10  {funct7, funct3} from ID/EX.
- RS1data_i  input  32  forwarded rs1 operand, already muxed by the forwarding unit.
- RS2data_i  input  32  forwarded rs2 operand.
- RDaddr_i  input  5  destination register from ID/EX.
- flush_i  input  1  synchronous abort of any operation in progress.
- stall_o  output  1  freeze request to the pipeline.
- busy_o  output  1  high in BUSY state.
- done_o  output  1  one-cycle result strobe.
- result_o  output  32  result; valid when done_o=1.
- RDaddr_o  output  5  rd of the completed operation; valid with done_o.

Behaviour:
- Reset (start_i=0, asynchronous): state=IDLE, counter=0, and all internal registers are cleared. Outputs: stall_o=0, busy_o=0, done_o=0, result_o=0, RDaddr_o=0.
- M-op detect is combinational: md_req = (ALUOp_i==2'b10) && (funct_7_3_i[9:3]==7'b0000001) && supported funct3.
- Supported funct3 in base build: 000 MUL, 011 MULHU, 101 DIVU, 111 REMU.
- Unsupported funct3 gives md_req=0; the instruction passes to the normal ALU untouched.
- State IDLE:
  - stall_o = md_req, combinational in the same cycle, so ID/EX holds.
  - On a clock edge with md_req=1 and flush_i=0: latch operands, funct3 and rd; counter=0; go to BUSY.
- State BUSY, one iteration per cycle, counter increments:
  - Multiply: shift-add over a 64-bit product register.
  - Divide: restoring shift-subtract, 32-bit remainder and quotient.
  - stall_o=1, busy_o=1.
  - When counter reaches XLEN-1 at a clock edge, go to DONE.
- State DONE:
  - stall_o=0, done_o=1; result_o and RDaddr_o are valid.
  - Next edge: go to IDLE unconditionally.
  - ID/EX advances on this edge, so the same instruction is never re-detected.
- Latency: detect cycle 0, BUSY cycles 1..32, DONE cycle 33. stall_o is high for 33 cycles (0..32).
- Result selection:
  - MUL = product[31:0].
  - MULHU = product[63:32].
  - DIVU = quotient.
  - REMU = remainder.
- Divide by zero (no trap): DIVU returns 0xFFFFFFFF and REMU returns the dividend. The iteration produces these naturally; no special case is needed.
- result_o and RDaddr_o hold their last value outside DONE; done_o is the only validity qualifier.
- flush_i=1 in any state: on the next edge, state=IDLE, done_o=0, no result is produced. flush_i takes priority over detect and over the DONE->IDLE transition.
- A back-to-back M-op (the next instruction in ID/EX) is detected in the IDLE cycle after DONE, which gives one free cycle between results.
- Reset mid-BUSY aborts immediately; no partial result is ever strobed.

Optional Feature:
- Macro: MD_SIGNED_EN.
- Defined: additionally supports 001 MULH, 010 MULHSU, 100 DIV, 110 REM.
  - Operands are converted to magnitudes at latch time, and the result is negated in DONE according to the latched signs.
  - DIV by zero = 0xFFFFFFFF; REM by zero = dividend.
  - Overflow 0x80000000 / 0xFFFFFFFF gives DIV=0x80000000 and REM=0.
  - Latency is unchanged (33 stall cycles).
- Undefined: these funct3 codes give md_req=0 and no stall. The sign logic is absent.

Test Plan:
- Reset mid-op: assert start_i low during BUSY cycle 10 -> all outputs 0 immediately. After release, IDLE with stall_o=0 and no done_o pulse.
- MUL, rs1=0x00001234, rs2=0x00005678, rd=5:
  - stall_o high for cycles 0..32.
  - Cycle 33: done_o=1, result_o=0x06260060, RDaddr_o=5.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> result_o=0xFFFFFFFE. Then MUL with the same operands issued right after -> result_o=0x00000001, with done pulses 34 cycles apart.
- DIVU 100/7 -> result_o=14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- flush_i pulsed in BUSY cycle 20 -> IDLE on the next edge, stall_o=0, no done_o. A new DIVU presented afterwards completes normally in 33 cycles.
- Non-M R-type (funct7=0000000, ADD) and MD_SIGNED_EN undefined with funct3=100 -> stall_o stays 0 and done_o never asserts. With MD_SIGNED_EN defined, DIV -7/2 -> 0xFFFFFFFD (-3) and REM -> 0xFFFFFFFF (-1).

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX -> multiply/divide unit request bus and result bus back toward EX/MEM.
// The master side is the pipeline (ID/EX register plus hazard logic); the
// slave side is ex_muldiv_unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic [1:0]      ALUOp_i;
    logic [9:0]      funct_7_3_i;
    logic [XLEN-1:0] RS1data_i;
    logic [XLEN-1:0] RS2data_i;
    logic [4:0]      RDaddr_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      RDaddr_o;

    modport master (
        output ALUOp_i, funct_7_3_i, RS1data_i, RS2data_i, RDaddr_i, flush_i,
        input  stall_o, busy_o, done_o, result_o, RDaddr_o
    );

    modport slave (
        input  ALUOp_i, funct_7_3_i, RS1data_i, RS2data_i, RDaddr_i, flush_i,
        output stall_o, busy_o, done_o, result_o, RDaddr_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle,
// 32 steps, result strobed for one cycle in DONE. The pipeline is frozen via
// stall_o from the detect cycle until the last iteration.
// Optional build macro MD_SIGNED_EN adds MULH, MULHSU, DIV and REM by working on
// magnitudes and negating the final result according to the latched signs.
// start_i is the asynchronous active-low reset of this block.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            start_i,
    ex_muldiv_unit_if.slave md_if
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
    logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand / divisor
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          rd_q, rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rdo_q, rdo_d;
`ifdef MD_SIGNED_EN
    logic                neg_q, neg_d;
    logic                neg_s;
    logic                a_sgn_s, b_sgn_s;
`endif

    logic [2:0]          f3_s;
    logic                f3_ok_s;
    logic                md_req_s;
    logic [XLEN-1:0]     op_a_s, op_b_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_sh_s;
    logic [XLEN-1:0]     div_sub_s;
    logic                div_ge_s;
    logic [2*XLEN-1:0]   iter_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s;
    logic [XLEN-1:0]     res_fin_s;

    // Decode whether the instruction in ID/EX belongs to this unit.
    always_comb begin
        f3_s = md_if.funct_7_3_i[2:0];
`ifdef MD_SIGNED_EN
        f3_ok_s = 1'b1;
`else
        case (f3_s)
            3'b000, 3'b011, 3'b101, 3'b111: f3_ok_s = 1'b1;
            default:                        f3_ok_s = 1'b0;
        endcase
`endif
        md_req_s = (md_if.ALUOp_i == 2'b10) &&
                   (md_if.funct_7_3_i[9:3] == 7'b0000001) && f3_ok_s;
    end

    // Operand preparation at latch time (magnitudes and result sign when signed ops exist).
    always_comb begin
`ifdef MD_SIGNED_EN
        case (f3_s)
            3'b001, 3'b100, 3'b110: begin
                a_sgn_s = md_if.RS1data_i[XLEN-1];
                b_sgn_s = md_if.RS2data_i[XLEN-1];
            end
            3'b010: begin
                a_sgn_s = md_if.RS1data_i[XLEN-1];
                b_sgn_s = 1'b0;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        op_a_s = a_sgn_s ? ({XLEN{1'b0}} - md_if.RS1data_i) : md_if.RS1data_i;
        op_b_s = b_sgn_s ? ({XLEN{1'b0}} - md_if.RS2data_i) : md_if.RS2data_i;
        // Divide by zero keeps the all-ones quotient unsigned; remainder follows the dividend.
        case (f3_s)
            3'b001, 3'b010: neg_s = a_sgn_s ^ b_sgn_s;
            3'b100:         neg_s = (a_sgn_s ^ b_sgn_s) && (md_if.RS2data_i != {XLEN{1'b0}});
            3'b110:         neg_s = a_sgn_s;
            default:        neg_s = 1'b0;
        endcase
`else
        op_a_s = md_if.RS1data_i;
        op_b_s = md_if.RS2data_i;
`endif
    end

    // One multiply or divide step applied to the working register.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_sh_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge_s  = (div_sh_s >= {1'b0, opb_q});
        div_sub_s = div_sh_s[XLEN-1:0] - opb_q;
        if (f3_q[2]) begin
            if (div_ge_s) begin
                iter_s = {div_sub_s, acc_q[XLEN-2:0], 1'b1};
            end else begin
                iter_s = {div_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            iter_s = {mul_sum_s, acc_q[XLEN-1:1]};
        end
    end

    // Final result selection from the last iteration, with sign fix-up if enabled.
    always_comb begin
`ifdef MD_SIGNED_EN
        prod_s = neg_q ? ({(2*XLEN){1'b0}} - iter_s) : iter_s;
        quo_s  = neg_q ? ({XLEN{1'b0}} - iter_s[XLEN-1:0]) : iter_s[XLEN-1:0];
        rem_s  = neg_q ? ({XLEN{1'b0}} - iter_s[2*XLEN-1:XLEN]) : iter_s[2*XLEN-1:XLEN];
`else
        prod_s = iter_s;
        quo_s  = iter_s[XLEN-1:0];
        rem_s  = iter_s[2*XLEN-1:XLEN];
`endif
        case (f3_q)
            3'b000:                 res_fin_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_fin_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_fin_s = quo_s;
            default:                res_fin_s = rem_s;
        endcase
    end

    // Next-state logic of the control FSM and datapath registers; flush wins over everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        rdo_d    = rdo_q;
`ifdef MD_SIGNED_EN
        neg_d    = neg_q;
`endif
        if (md_if.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (md_req_s) begin
                        acc_d   = {{XLEN{1'b0}}, op_a_s};
                        opb_d   = op_b_s;
                        f3_d    = f3_s;
                        rd_d    = md_if.RDaddr_i;
                        cnt_d   = {CNT_W{1'b0}};
                        busy_d  = 1'b1;
                        state_d = ST_BUSY;
`ifdef MD_SIGNED_EN
                        neg_d   = neg_s;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_d = iter_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = res_fin_s;
                        rdo_d    = rd_q;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        busy_d   = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            opb_q    <= {XLEN{1'b0}};
            f3_q     <= 3'b000;
            rd_q     <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
            rdo_q    <= 5'd0;
`ifdef MD_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rdo_q    <= rdo_d;
`ifdef MD_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    // stall_o must cover the detect cycle, so it is decoded from state and md_req.
    assign md_if.stall_o  = ((state_q == ST_IDLE) && md_req_s) || (state_q == ST_BUSY);
    assign md_if.busy_o   = busy_q;
    assign md_if.done_o   = done_q;
    assign md_if.result_o = result_q;
    assign md_if.RDaddr_o = rdo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed, table-driven bench for ex_muldiv_unit plus hand-written sequences
// for flush, asynchronous reset in the middle of an operation and strobe width.
module tb_ex_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   tick  = 0;
    int   last_done_tick = 0;

    ex_muldiv_unit_if md_if ();

    ex_muldiv_unit dut (
        .clk_i   (clk),
        .start_i (rst_n),
        .md_if   (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    typedef struct packed {
        logic [1:0]  alu;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        is_md;
        logic        chk_gap;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] alu, input logic [6:0] f7,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input logic is_md, input logic chk_gap,
                                input logic [31:0] exp);
        vec_t v;
        v.alu = alu; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b; v.rd = rd;
        v.is_md = is_md; v.chk_gap = chk_gap; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic present(input vec_t v);
        md_if.ALUOp_i     = v.alu;
        md_if.funct_7_3_i = {v.f7, v.f3};
        md_if.RS1data_i   = v.a;
        md_if.RS2data_i   = v.b;
        md_if.RDaddr_i    = v.rd;
        md_if.flush_i     = 1'b0;
    endtask

    task automatic idle_inputs();
        md_if.ALUOp_i     = 2'b00;
        md_if.funct_7_3_i = 10'd0;
        md_if.RS1data_i   = 32'd0;
        md_if.RS2data_i   = 32'd0;
        md_if.RDaddr_i    = 5'd0;
        md_if.flush_i     = 1'b0;
    endtask

    // Present a vector in cycle 0 and follow it until done or a 40-cycle budget.
    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          stall_hi;
        int          done_cyc;
        int          dtick;
        logic        got;
        logic [31:0] res;
        logic [4:0]  rdo;
        present(v);
        cyc = 0; stall_hi = 0; done_cyc = -1; dtick = 0; got = 1'b0;
        res = 32'd0; rdo = 5'd0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (md_if.stall_o) stall_hi++;
            if (md_if.done_o) begin
                got = 1'b1; done_cyc = cyc; dtick = tick;
                res = md_if.result_o; rdo = md_if.RDaddr_o;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (v.is_md) begin
            chk("done_cycle", idx, done_cyc, 32'd33);
            chk("stall_cycles", idx, stall_hi, 32'd33);
            chk("result", idx, res, v.exp);
            chk("rd", idx, {27'd0, rdo}, {27'd0, v.rd});
            if (v.chk_gap) chk("done_gap", idx, dtick - last_done_tick, 32'd34);
            last_done_tick = dtick;
        end else begin
            chk("no_md_stall", idx, stall_hi, 32'd0);
            chk("no_md_done", idx, {31'd0, got}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        int st;
        vec_t v;
        localparam logic [6:0] M7 = 7'b0000001;

        vecs.push_back(mk(2'b10, M7, 3'b000, 32'h00001234, 32'h00005678, 5'd5,  1'b1, 1'b0, 32'h06260060));
        vecs.push_back(mk(2'b10, M7, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b1, 1'b1, 32'hFFFFFFFE));
        vecs.push_back(mk(2'b10, M7, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b1, 1'b1, 32'h00000001));
        vecs.push_back(mk(2'b10, M7, 3'b101, 32'd100,      32'd7,        5'd8,  1'b1, 1'b1, 32'd14));
        vecs.push_back(mk(2'b10, M7, 3'b111, 32'd100,      32'd7,        5'd9,  1'b1, 1'b1, 32'd2));
        vecs.push_back(mk(2'b10, M7, 3'b101, 32'd5,        32'd0,        5'd10, 1'b1, 1'b0, 32'hFFFFFFFF));
        vecs.push_back(mk(2'b10, M7, 3'b111, 32'd5,        32'd0,        5'd11, 1'b1, 1'b0, 32'd5));
        vecs.push_back(mk(2'b10, M7, 3'b000, 32'h80000000, 32'd2,        5'd12, 1'b1, 1'b0, 32'h00000000));
        vecs.push_back(mk(2'b10, M7, 3'b011, 32'h80000000, 32'd2,        5'd13, 1'b1, 1'b0, 32'h00000001));
        vecs.push_back(mk(2'b10, M7, 3'b101, 32'hFFFFFFFF, 32'd1,        5'd14, 1'b1, 1'b0, 32'hFFFFFFFF));
        vecs.push_back(mk(2'b10, M7, 3'b111, 32'h12345678, 32'h00000100, 5'd15, 1'b1, 1'b0, 32'h00000078));
        vecs.push_back(mk(2'b10, M7, 3'b101, 32'd7,        32'd100,      5'd31, 1'b1, 1'b0, 32'd0));
`ifdef MD_SIGNED_EN
        vecs.push_back(mk(2'b10, M7, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd16, 1'b1, 1'b0, 32'hFFFFFFFD));
        vecs.push_back(mk(2'b10, M7, 3'b110, 32'hFFFFFFF9, 32'd2,        5'd17, 1'b1, 1'b0, 32'hFFFFFFFF));
        vecs.push_back(mk(2'b10, M7, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 1'b1, 1'b0, 32'h80000000));
        vecs.push_back(mk(2'b10, M7, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 1'b1, 1'b0, 32'h00000000));
        vecs.push_back(mk(2'b10, M7, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 1'b1, 1'b0, 32'h00000000));
        vecs.push_back(mk(2'b10, M7, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 1'b1, 1'b0, 32'hFFFFFFFF));
        vecs.push_back(mk(2'b10, M7, 3'b001, 32'h80000000, 32'h80000000, 5'd22, 1'b1, 1'b0, 32'h40000000));
        vecs.push_back(mk(2'b10, M7, 3'b100, 32'd5,        32'd0,        5'd23, 1'b1, 1'b0, 32'hFFFFFFFF));
        vecs.push_back(mk(2'b10, M7, 3'b110, 32'hFFFFFFFB, 32'd0,        5'd24, 1'b1, 1'b0, 32'hFFFFFFFB));
`else
        vecs.push_back(mk(2'b10, M7, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd16, 1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(2'b10, M7, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(2'b10, M7, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(2'b10, M7, 3'b110, 32'hFFFFFFF9, 32'd2,        5'd19, 1'b0, 1'b0, 32'd0));
`endif
        vecs.push_back(mk(2'b10, 7'b0000000, 3'b000, 32'd3, 32'd4, 5'd1, 1'b0, 1'b0, 32'd0));
        vecs.push_back(mk(2'b00, M7,         3'b000, 32'd3, 32'd4, 5'd2, 1'b0, 1'b0, 32'd0));

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_stall",  0, {31'd0, md_if.stall_o}, 32'd0);
        chk("rst_busy",   0, {31'd0, md_if.busy_o},  32'd0);
        chk("rst_done",   0, {31'd0, md_if.done_o},  32'd0);
        chk("rst_result", 0, md_if.result_o,         32'd0);
        chk("rst_rd",     0, {27'd0, md_if.RDaddr_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: M-ops run back to back, then instructions that must bypass the unit
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush in BUSY cycle 20 aborts without a result
        v = mk(2'b10, M7, 3'b101, 32'd1000, 32'd3, 5'd9, 1'b1, 1'b0, 32'd333);
        present(v);
        repeat (20) begin @(posedge clk); #1; end
        md_if.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", 100, {31'd0, md_if.busy_o}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("flush_stall", 100, {31'd0, md_if.stall_o}, 32'd0);
        chk("flush_busy",  100, {31'd0, md_if.busy_o},  32'd0);
        chk("flush_done",  100, {31'd0, md_if.done_o},  32'd0);
        dn = 0;
        repeat (40) begin @(negedge clk); if (md_if.done_o) dn++; end
        chk("flush_no_done", 100, dn, 32'd0);
        @(posedge clk); #1;
        run_vec(101, v);

        // done_o is a single-cycle strobe
        idle_inputs();
        @(negedge clk);
        chk("done_strobe_width", 102, {31'd0, md_if.done_o}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset during BUSY cycle 10
        v = mk(2'b10, M7, 3'b000, 32'h00001234, 32'h00005678, 5'd7, 1'b1, 1'b0, 32'h06260060);
        present(v);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_stall",  103, {31'd0, md_if.stall_o}, 32'd0);
        chk("midrst_busy",   103, {31'd0, md_if.busy_o},  32'd0);
        chk("midrst_done",   103, {31'd0, md_if.done_o},  32'd0);
        chk("midrst_result", 103, md_if.result_o,         32'd0);
        chk("midrst_rd",     103, {27'd0, md_if.RDaddr_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0; st = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_if.done_o) dn++;
            if (md_if.stall_o) st++;
        end
        chk("midrst_no_done",  104, dn, 32'd0);
        chk("midrst_no_stall", 104, st, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
